// File: rtl/pixel_sink.sv
// Pixel-plot sink: buffers (x, y, colour) strobes in a FIFO and issues one handshaked
// framebuffer write per pixel. Define PIXEL_SINK_CLIP_EN to drop off-grid pixels.
module pixel_sink #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned WIDTH      = 160,
  parameter int unsigned HEIGHT     = 120,
  parameter int unsigned ADDR_W     = 15
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [7:0]        in_x,
  input  logic [6:0]        in_y,
  input  logic [2:0]        in_colour,
  input  logic              in_plot,
  output logic              in_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [2:0]        mem_data,
  output logic              mem_we,
  input  logic              mem_ack,
  output logic [15:0]       pixels_written,
  output logic              overflow
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] colour;
  } pixel_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ADDR  = 2'd1,
    WRITE = 2'd2
  } state_t;

  pixel_t             fifo_mem [FIFO_DEPTH];
  logic [CNT_W-1:0]   wr_ptr;
  logic [CNT_W-1:0]   rd_ptr;
  logic               fifo_empty;
  logic               fifo_full;
  logic               push;
  pixel_t             work;
  state_t             state_q;
  state_t             state_d;
  logic               pop_c;
  logic               load_c;
  logic               done_c;
  logic               clip_c;
  logic               in_range;
  logic [ADDR_W-1:0]  y_ext;
  logic [ADDR_W-1:0]  addr_calc;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                      (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
  assign in_ready   = ~fifo_full;
  assign push       = in_plot & in_ready;

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr[PTR_W-1:0]] <= '{x: in_x, y: in_y, colour: in_colour};
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push)  wr_ptr <= wr_ptr + CNT_W'(1);
      if (pop_c) rd_ptr <= rd_ptr + CNT_W'(1);
    end
  end

  // A plot offered while full is lost; remember that until reset.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      overflow <= 1'b0;
    end else if (in_plot && !in_ready) begin
      overflow <= 1'b1;
    end
  end

  // y*160 + x as two shifts and an add, wrapped to the address width.
  assign y_ext     = ADDR_W'(work.y);
  assign addr_calc = (y_ext << 7) + (y_ext << 5) + ADDR_W'(work.x);
  assign in_range  = (32'(work.x) < WIDTH) && (32'(work.y) < HEIGHT);

`ifdef PIXEL_SINK_CLIP_EN
  assign clip_c = ~in_range;
`else
  logic unused_range;
  assign unused_range = in_range;
  assign clip_c       = 1'b0;
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (!fifo_empty) state_d = ADDR;
      ADDR:    state_d = clip_c ? IDLE : WRITE;
      WRITE:   if (mem_ack) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    pop_c  = 1'b0;
    load_c = 1'b0;
    done_c = 1'b0;
    case (state_q)
      IDLE:    pop_c  = !fifo_empty;
      ADDR:    load_c = !clip_c;
      WRITE:   done_c = mem_ack;
      default: ;
    endcase
  end

  // Working entry and registered memory-port outputs.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      work           <= '0;
      mem_addr       <= '0;
      mem_data       <= '0;
      mem_we         <= 1'b0;
      pixels_written <= '0;
    end else begin
      if (pop_c) work <= fifo_mem[rd_ptr[PTR_W-1:0]];
      if (load_c) begin
        mem_addr <= addr_calc;
        mem_data <= work.colour;
      end
      mem_we <= (state_d == WRITE);
      if (done_c) pixels_written <= pixels_written + 16'd1;
    end
  end

endmodule

// File: tb/tb_pixel_sink.sv
// Self-checking bench for pixel_sink: vector table, hand-written corner sequences and a
// randomized run against a transaction-level reference model.
module tb_pixel_sink;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned W     = 160;
  localparam int unsigned H     = 120;
  localparam int unsigned AW    = 15;
`ifdef PIXEL_SINK_CLIP_EN
  localparam bit CLIP = 1'b1;
`else
  localparam bit CLIP = 1'b0;
`endif

  logic          clk;
  logic          resetn;
  logic [7:0]    in_x;
  logic [6:0]    in_y;
  logic [2:0]    in_colour;
  logic          in_plot;
  logic          in_ready;
  logic [AW-1:0] mem_addr;
  logic [2:0]    mem_data;
  logic          mem_we;
  logic          mem_ack;
  logic [15:0]   pixels_written;
  logic          overflow;

  pixel_sink #(.FIFO_DEPTH(DEPTH), .WIDTH(W), .HEIGHT(H), .ADDR_W(AW)) dut (
    .clk(clk), .resetn(resetn), .in_x(in_x), .in_y(in_y), .in_colour(in_colour),
    .in_plot(in_plot), .in_ready(in_ready), .mem_addr(mem_addr), .mem_data(mem_data),
    .mem_we(mem_we), .mem_ack(mem_ack), .pixels_written(pixels_written), .overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: pending queue plus one pixel in service. A popped pixel spends one
  // edge being addressed, then is written on the first acked edge after that.
  typedef struct {
    int x;
    int y;
    int c;
  } pix_t;

  pix_t mq[$];
  pix_t fl;
  bit   busy    = 1'b0;
  int   age     = 0;
  int   m_count = 0;
  bit   m_ovf   = 1'b0;
  bit   m_acc;
  bit   chk_en  = 1'b0;

  function automatic int addr_of(input pix_t p);
    return (p.y * W + p.x) % (1 << AW);
  endfunction

  function automatic bit clipped(input pix_t p);
    return CLIP && (p.x >= W || p.y >= H);
  endfunction

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      mq.delete();
      busy    = 1'b0;
      age     = 0;
      m_count = 0;
      m_ovf   = 1'b0;
    end else begin
      m_acc = in_plot && (mq.size() < DEPTH);
      if (in_plot && !m_acc) m_ovf = 1'b1;
      if (busy) begin
        if (age == 0) begin
          if (clipped(fl)) busy = 1'b0;
          else age = 1;
        end else if (mem_ack) begin
          busy    = 1'b0;
          m_count = (m_count + 1) % 65536;
        end
      end else if (mq.size() > 0) begin
        fl   = mq.pop_front();
        busy = 1'b1;
        age  = 0;
      end
      if (m_acc) mq.push_back('{int'(in_x), int'(in_y), int'(in_colour)});
    end
  end

  // Cycle-by-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("m_in_ready", in_ready, mq.size() < DEPTH);
      chk("m_mem_we", mem_we, busy && age >= 1);
      if (busy && age >= 1) begin
        chk("m_mem_addr", mem_addr, addr_of(fl));
        chk("m_mem_data", mem_data, fl.c);
      end
      chk("m_pixels_written", pixels_written, m_count);
      chk("m_overflow", overflow, m_ovf);
    end
  end

  task automatic do_reset();
    @(negedge clk);
    #2;
    resetn  = 1'b0;
    in_plot = 1'b0;
    mem_ack = 1'b0;
    @(negedge clk);
    #2;
    resetn = 1'b1;
  endtask

  typedef struct {
    int x;
    int y;
    int c;
    bit exp_we;
    int exp_addr;
  } vec_t;

  vec_t tv[6];
  int   n_done;
  int   got[$];
  bit   seen;
  logic [AW-1:0] hold_addr;
  logic [2:0]    hold_data;

  initial begin
    resetn = 1'b0; in_plot = 1'b0; in_x = '0; in_y = '0; in_colour = '0; mem_ack = 1'b0;
    tv[0] = '{3,   2,   6, 1'b1,  323};
    tv[1] = '{159, 119, 5, 1'b1,  19199};
    tv[2] = '{0,   0,   7, 1'b1,  0};
    tv[3] = '{10,  50,  1, 1'b1,  8010};
    tv[4] = '{160, 0,   2, !CLIP, 160};
    tv[5] = '{255, 127, 4, !CLIP, 20575};
    repeat (2) @(negedge clk);
    #2 resetn = 1'b1;
    chk_en = 1'b1;

    @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_data", mem_data, 0);
    chk("rst_pixels_written", pixels_written, 0);
    chk("rst_overflow", overflow, 0);

    // Single pixels with ack tied high: we must pulse for one cycle after T+2.
    n_done = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      in_plot = 1'b1; in_x = 8'(tv[i].x); in_y = 7'(tv[i].y); in_colour = 3'(tv[i].c);
      mem_ack = 1'b1;
      @(negedge clk);
      in_plot = 1'b0;
      @(negedge clk);
      chk($sformatf("vec%0d_we_t1", i), mem_we, 0);
      @(negedge clk);
      chk($sformatf("vec%0d_we_t2", i), mem_we, tv[i].exp_we);
      if (tv[i].exp_we) begin
        chk($sformatf("vec%0d_addr", i), mem_addr, tv[i].exp_addr);
        chk($sformatf("vec%0d_data", i), mem_data, tv[i].c);
      end
      @(negedge clk);
      chk($sformatf("vec%0d_we_t3", i), mem_we, 0);
      n_done += int'(tv[i].exp_we);
      chk($sformatf("vec%0d_count", i), pixels_written, n_done);
    end

    // Stall: six plots with ack low, five fit, the sixth overflows.
    do_reset();
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (i == 4) chk("stall_ready_before5", in_ready, 1);
      if (i == 5) chk("stall_ready_after5", in_ready, 0);
      in_plot = 1'b1; in_x = 8'(20 + i); in_y = 7'(i); in_colour = 3'(i + 1);
    end
    @(negedge clk);
    in_plot = 1'b0;
    chk("stall_overflow", overflow, 1);
    chk("stall_ready_full", in_ready, 0);
    mem_ack = 1'b1;
    got.delete();
    for (int k = 0; k < 40; k++) begin
      if (mem_we && mem_ack) got.push_back(int'(mem_addr));
      @(negedge clk);
    end
    chk("stall_write_count", got.size(), 5);
    for (int i = 0; i < 5 && i < got.size(); i++)
      chk($sformatf("stall_order%0d", i), got[i], i * 160 + 20 + i);
    chk("stall_pixels_written", pixels_written, 5);
    chk("stall_overflow_sticky", overflow, 1);

    // Ack arrives four cycles after we rises; port must hold steady meanwhile.
    do_reset();
    @(negedge clk);
    in_plot = 1'b1; in_x = 8'd50; in_y = 7'd60; in_colour = 3'd3;
    @(negedge clk);
    in_plot = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 10 && !seen; k++) begin
      @(negedge clk);
      seen = mem_we;
    end
    chk("lat_we_rise", seen, 1);
    hold_addr = mem_addr;
    hold_data = mem_data;
    chk("lat_addr", hold_addr, 9650);
    chk("lat_data", hold_data, 3);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      chk($sformatf("lat_we_c%0d", k), mem_we, 1);
      chk($sformatf("lat_addr_c%0d", k), mem_addr, 9650);
      chk($sformatf("lat_data_c%0d", k), mem_data, 3);
      if (k == 4) mem_ack = 1'b1;
    end
    @(negedge clk);
    mem_ack = 1'b0;
    chk("lat_we_drop", mem_we, 0);
    chk("lat_count", pixels_written, 1);
    repeat (3) @(negedge clk);
    chk("lat_count_hold", pixels_written, 1);

    // Reset while writing with two entries still queued.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      in_plot = 1'b1; in_x = 8'(5 + i); in_y = 7'(9); in_colour = 3'(i);
    end
    @(negedge clk);
    in_plot = 1'b0;
    chk("rmw_we_before", mem_we, 1);
    #2 resetn = 1'b0;
    #1;
    chk("rmw_we_async", mem_we, 0);
    @(negedge clk);
    #2 resetn = 1'b1;
    mem_ack = 1'b1;
    @(negedge clk);
    chk("rmw_ready", in_ready, 1);
    chk("rmw_count", pixels_written, 0);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk("rmw_no_we", mem_we, 0);
    end

    // Randomized traffic with bursty plots and irregular acks.
    do_reset();
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      in_plot   = ($urandom % 100) < 55;
      in_x      = 8'($urandom % 256);
      in_y      = 7'($urandom % 128);
      in_colour = 3'($urandom % 8);
      mem_ack   = ($urandom % 100) < ((k / 500) % 2 == 0 ? 45 : 90);
    end
    @(negedge clk);
    in_plot = 1'b0;
    mem_ack = 1'b1;
    repeat (40) @(negedge clk);
    chk("rand_drained_ready", in_ready, 1);
    chk("rand_drained_we", mem_we, 0);

    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, required finish");
    $fatal(1, "watchdog");
  end

endmodule
